// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction fetch sequencer for the word-indexed ROM.
// Holds the PC and issues one ROM read per cycle into a 2-entry prefetch
// queue. Decode sees the queue head through a valid/ready handshake.
// A branch/jump redirect flushes the queue and reloads the PC. Fetch halts
// once the PC runs past the populated ROM depth.
module imem_fetch_ctrl #(
   parameter int          MEM_DEPTH = 16,
   parameter logic [31:0] BOOT_PC   = 32'd0,
   parameter int          CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic [31:0]      imem_addr,
   input  logic [31:0]      imem_instr,
   output logic             instr_valid,
   input  logic             instr_ready,
   output logic [31:0]      instr_out,
   output logic [31:0]      instr_pc,
   input  logic             redirect_valid,
   input  logic [31:0]      redirect_pc,
   output logic             busy,
   output logic             halted,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

   localparam logic [31:0] LAST_PC = 32'(MEM_DEPTH - 1);
   localparam logic [31:0] DEPTH32 = 32'(MEM_DEPTH);

   state_t      state;
   state_t      state_next;
   logic [31:0] pc;
   logic [1:0]  count;
   logic [1:0]  count_next;
   logic [31:0] q1_instr;
   logic [31:0] q1_pc;
   logic        pop;
   logic        issue;
   logic        target_ok;

   assign imem_addr = pc;

   // Handshake, fetch issue and next-state decisions; redirect has priority.
   always_comb begin
      pop        = instr_valid && instr_ready;
      issue      = (state == RUN) && !redirect_valid && ((count != 2'd2) || pop);
      target_ok  = redirect_pc < DEPTH32;
      state_next = state;
      count_next = count + {1'b0, issue} - {1'b0, pop};
      if (redirect_valid) begin
         count_next = 2'd0;
         case (state)
            RUN:     if (!target_ok) state_next = HALT;
            HALT:    if (target_ok)  state_next = RUN;
            default: state_next = state;
         endcase
      end else begin
         case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (issue && (pc == LAST_PC)) state_next = HALT;
            default: state_next = state;
         endcase
      end
   end

   // State, PC, counter and queue storage with registered status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= BOOT_PC;
         count       <= 2'd0;
         instr_valid <= 1'b0;
         instr_out   <= 32'd0;
         instr_pc    <= 32'd0;
         q1_instr    <= 32'd0;
         q1_pc       <= 32'd0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         fetch_count <= '0;
      end else begin
         state       <= state_next;
         busy        <= (state_next == RUN);
         halted      <= (state_next == HALT);
         count       <= count_next;
         instr_valid <= (count_next != 2'd0);

         if (redirect_valid)
            pc <= redirect_pc;
         else if (issue)
            pc <= pc + 32'd1;
         else if ((state == IDLE) && start)
            pc <= BOOT_PC;

         if (issue)
            fetch_count <= fetch_count + 1'b1;

         // Flushed entries are simply forgotten via count; data regs may keep
         // stale values because instr_valid qualifies them.
         if (!redirect_valid) begin
            // Head slot: advance from slot 1, or take the new fetch when the
            // head is empty or being consumed with nothing behind it.
            if (pop && (count == 2'd2)) begin
               instr_out <= q1_instr;
               instr_pc  <= q1_pc;
            end else if (issue && ((count == 2'd0) || ((count == 2'd1) && pop))) begin
               instr_out <= imem_instr;
               instr_pc  <= pc;
            end
            // Second slot: new fetch lands behind a head that stays.
            if (issue && ((count == 2'd2) || ((count == 2'd1) && !pop))) begin
               q1_instr <= imem_instr;
               q1_pc    <= pc;
            end
         end
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: directed scenarios plus a randomized phase,
// checked every cycle against a queue-based behavioural model. A second
// instance with a 4-bit fetch counter shares the stimulus to observe wrap.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, instr_ready, redirect_valid;
   logic [31:0] redirect_pc;

   logic [31:0] imem_addr, imem_instr, instr_out, instr_pc;
   logic        instr_valid, busy, halted;
   logic [15:0] fetch_count;

   logic [31:0] imem_addr_w, imem_instr_w, instr_out_w, instr_pc_w;
   logic        instr_valid_w, busy_w, halted_w;
   logic [3:0]  fetch_count_w;

   logic [31:0] rom [16];

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ent_t;

   localparam int M_IDLE = 0, M_RUN = 1, M_HALT = 2;
   int          m_state;
   logic [31:0] m_pc;
   int          m_cnt;
   ent_t        mq[$];

   always #5 clk = ~clk;

   assign imem_instr   = (imem_addr   < 32'd16) ? rom[imem_addr[3:0]]   : 32'd0;
   assign imem_instr_w = (imem_addr_w < 32'd16) ? rom[imem_addr_w[3:0]] : 32'd0;

   imem_fetch_ctrl #(.MEM_DEPTH(16), .BOOT_PC(32'd0), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr),
      .imem_instr(imem_instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_out(instr_out), .instr_pc(instr_pc), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .busy(busy), .halted(halted), .fetch_count(fetch_count)
   );

   imem_fetch_ctrl #(.MEM_DEPTH(16), .BOOT_PC(32'd0), .CNT_W(4)) dut_w (
      .clk(clk), .rst(rst), .start(start), .imem_addr(imem_addr_w),
      .imem_instr(imem_instr_w), .instr_valid(instr_valid_w), .instr_ready(instr_ready),
      .instr_out(instr_out_w), .instr_pc(instr_pc_w), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .busy(busy_w), .halted(halted_w), .fetch_count(fetch_count_w)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Behavioural model: apply the fetch rules to the sampled inputs at one edge.
   task automatic model_edge();
      bit   pop;
      int   occ;
      ent_t e;
      if (rst) begin
         m_state = M_IDLE;
         m_pc    = 32'd0;
         m_cnt   = 0;
         mq.delete();
         return;
      end
      occ = mq.size();
      pop = (occ > 0) && instr_ready;
      if (pop)
         $display("xfer pc=%0d instr=%h", mq[0].pc, mq[0].instr);
      if (redirect_valid) begin
         mq.delete();
         m_pc = redirect_pc;
         if (m_state == M_RUN && redirect_pc >= 32'd16) m_state = M_HALT;
         else if (m_state == M_HALT && redirect_pc < 32'd16) m_state = M_RUN;
      end else begin
         if (pop) void'(mq.pop_front());
         if (m_state == M_RUN && (occ < 2 || pop)) begin
            e.pc    = m_pc;
            e.instr = (m_pc < 32'd16) ? rom[m_pc[3:0]] : 32'd0;
            mq.push_back(e);
            m_cnt++;
            if (m_pc == 32'd15) m_state = M_HALT;
            m_pc = m_pc + 32'd1;
         end else if (m_state == M_IDLE && start) begin
            m_state = M_RUN;
            m_pc    = 32'd0;
         end
      end
   endtask

   task automatic check_all();
      bit v;
      v = (mq.size() > 0);
      chk("instr_valid", {31'd0, instr_valid}, {31'd0, v});
      chk("instr_valid_w", {31'd0, instr_valid_w}, {31'd0, v});
      if (v) begin
         chk("instr_out", instr_out, mq[0].instr);
         chk("instr_pc", instr_pc, mq[0].pc);
         chk("instr_pc_w", instr_pc_w, mq[0].pc);
      end
      chk("busy", {31'd0, busy}, {31'd0, m_state == M_RUN});
      chk("halted", {31'd0, halted}, {31'd0, m_state == M_HALT});
      chk("busy_w", {31'd0, busy_w}, {31'd0, m_state == M_RUN});
      chk("imem_addr", imem_addr, m_pc);
      chk("imem_addr_w", imem_addr_w, m_pc);
      chk("fetch_count", {16'd0, fetch_count}, {16'd0, m_cnt[15:0]});
      chk("fetch_count_w", {28'd0, fetch_count_w}, {28'd0, m_cnt[3:0]});
   endtask

   // One clock: drive inputs, advance the model at the edge, compare after it.
   task automatic step(input logic s, input logic rdy, input logic rv,
                       input logic [31:0] rp, input logic rs);
      rst            = rs;
      start          = s;
      instr_ready    = rdy;
      redirect_valid = rv;
      redirect_pc    = rp;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   initial begin
      int saved_cnt;
      rst = 1'b1; start = 1'b0; instr_ready = 1'b0;
      redirect_valid = 1'b0; redirect_pc = 32'd0;
      for (int i = 0; i < 16; i++) rom[i] = $urandom;
      rom[0] = 32'h8E510002;

      // Reset state.
      step(0, 0, 0, 0, 1);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_fc", {16'd0, fetch_count}, 32'd0);

      // Linear run.
      step(0, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      chk("lin_busy", {31'd0, busy}, 32'd1);
      chk("lin_valid_e", {31'd0, instr_valid}, 32'd0);
      step(0, 1, 0, 0, 0);
      chk("lin_first_instr", instr_out, 32'h8E510002);
      chk("lin_first_pc", instr_pc, 32'd0);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);
      chk("lin_halted", {31'd0, halted}, 32'd1);
      chk("lin_fc", {16'd0, fetch_count}, 32'd16);

      // Back-pressure.
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
      chk("bp_addr", imem_addr, 32'd2);
      chk("bp_fc", {16'd0, fetch_count}, 32'd2);
      chk("bp_pc_hold", instr_pc, 32'd0);
      for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0);

      // Redirect with PCs 3 and 4 pending.
      step(0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 20 && !(mq.size() > 0 && mq[0].pc == 32'd3); i++)
         step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("rd_q_head", instr_pc, 32'd3);
      step(0, 1, 1, 32'd9, 0);
      chk("rd_bubble", {31'd0, instr_valid}, 32'd0);
      step(0, 1, 0, 0, 0);
      chk("rd_target_pc", instr_pc, 32'd9);
      chk("rd_target_v", {31'd0, instr_valid}, 32'd1);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

      // Out-of-range redirect, then recovery from HALT.
      step(0, 1, 1, 32'd20, 0);
      chk("oor_halted", {31'd0, halted}, 32'd1);
      saved_cnt = m_cnt;
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
      chk("oor_fc_frozen", {16'd0, fetch_count}, 32'(saved_cnt));
      step(0, 1, 1, 32'd2, 0);
      chk("oor_busy", {31'd0, busy}, 32'd1);
      step(0, 1, 0, 0, 0);
      chk("oor_pc2", instr_pc, 32'd2);
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);

      // Mid-operation reset with a full queue and a redirect.
      step(0, 0, 0, 0, 1);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
      step(0, 1, 1, 32'd7, 1);
      chk("mr_valid", {31'd0, instr_valid}, 32'd0);
      chk("mr_out", instr_out, 32'd0);
      chk("mr_pc", instr_pc, 32'd0);
      chk("mr_busy", {31'd0, busy}, 32'd0);
      chk("mr_halted", {31'd0, halted}, 32'd0);
      chk("mr_addr", imem_addr, 32'd0);
      chk("mr_fc", {16'd0, fetch_count}, 32'd0);
      step(0, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("mr_idle", {31'd0, busy}, 32'd0);
      step(1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      chk("mr_boot_pc", instr_pc, 32'd0);
      chk("mr_boot_v", {31'd0, instr_valid}, 32'd1);

      // Counter wrap on the 4-bit instance.
      step(0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 30 && m_pc != 32'd15; i++) step(0, 1, 0, 0, 0);
      step(0, 1, 1, 32'd0, 0);
      chk("wrap_15", {28'd0, fetch_count_w}, 32'd15);
      step(0, 1, 0, 0, 0);
      chk("wrap_0", {28'd0, fetch_count_w}, 32'd0);
      chk("wrap_wide", {16'd0, fetch_count}, 32'd16);

      // Randomized traffic.
      step(0, 0, 0, 0, 1);
      step(1, 1, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         logic        rv;
         logic [31:0] rp;
         rv = ($urandom_range(0, 15) == 0);
         rp = 32'($urandom_range(0, 19));
         step(0, ($urandom_range(0, 3) != 0), rv, rp, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
